// File: rtl/id_rf_sched.sv
// Decode-stage register-file port scheduler: arbitrates the single RF port between
// write-back and operand reads, and drives load-use stall / jump flush controls.
module id_rf_sched #(
    parameter int unsigned MAX_WB_BURST = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs2,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        wb_ready,
    input  logic        control_j,
    output logic        rf_op_write,
    output logic [4:0]  rf_write_addr,
    output logic [31:0] rf_write_data,
    output logic [4:0]  rf_read_addr1,
    output logic [4:0]  rf_read_addr2,
    input  logic [31:0] rf_read_value1,
    input  logic [31:0] rf_read_value2,
    output logic [31:0] opnd1,
    output logic [31:0] opnd2,
    output logic        opnd_valid,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic [2:0]  grant_state
);

    typedef enum logic [2:0] {
        GntIdle  = 3'd0,
        GntRd    = 3'd1,
        GntWr    = 3'd2,
        GntStall = 3'd3,
        GntFlush = 3'd4
    } grant_e;

    localparam logic [2:0] MaxBurst = 3'(MAX_WB_BURST);

    grant_e      w_grant;
    grant_e      r_grant;
    logic        w_lu;
    logic        w_wr_ok;
    logic [2:0]  r_burst_cnt;
    logic [31:0] r_opnd1;
    logic [31:0] r_opnd2;
    logic        r_opnd_valid;
    logic [31:0] w_opnd1;
    logic [31:0] w_opnd2;

    assign w_lu = id_valid & ex_mem_read & (ex_rd != 5'd0) &
                  ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
    assign w_wr_ok = wb_valid & (~id_valid | (r_burst_cnt < MaxBurst));

    always_comb begin
        w_grant     = GntIdle;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        rf_op_write = 1'b0;
        wb_ready    = 1'b0;
        if (control_j) begin
            w_grant     = GntFlush;
            ifid_flush  = 1'b1;
            ifid_write  = 1'b0;
            rf_op_write = wb_valid;
            wb_ready    = wb_valid;
        end else if (w_lu) begin
            w_grant     = GntStall;
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            rf_op_write = wb_valid;
            wb_ready    = wb_valid;
        end else if (w_wr_ok) begin
            w_grant     = GntWr;
            rf_op_write = 1'b1;
            wb_ready    = 1'b1;
            pc_write    = ~id_valid;
            ifid_write  = ~id_valid;
        end else if (id_valid) begin
            w_grant = GntRd;
        end
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b0;
            rf_op_write = 1'b0;
            wb_ready    = 1'b0;
        end
    end

    // Register 0 reads as zero; a pending write to the same register bypasses the RF.
    always_comb begin
        w_opnd1 = rf_read_value1;
        w_opnd2 = rf_read_value2;
        if (id_rs1 == 5'd0) begin
            w_opnd1 = 32'd0;
        end else if (wb_valid && (wb_rd == id_rs1)) begin
            w_opnd1 = wb_data;
        end
        if (id_rs2 == 5'd0) begin
            w_opnd2 = 32'd0;
        end else if (wb_valid && (wb_rd == id_rs2)) begin
            w_opnd2 = wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_grant      <= GntIdle;
            r_burst_cnt  <= 3'd0;
            r_opnd1      <= 32'd0;
            r_opnd2      <= 32'd0;
            r_opnd_valid <= 1'b0;
        end else begin
            r_grant      <= w_grant;
            r_opnd_valid <= (w_grant == GntRd);
            if (w_grant == GntRd) begin
                r_opnd1 <= w_opnd1;
                r_opnd2 <= w_opnd2;
            end
            if ((w_grant == GntRd) || !id_valid) begin
                r_burst_cnt <= 3'd0;
            end else if ((w_grant == GntWr) && (r_burst_cnt != 3'd7)) begin
                r_burst_cnt <= r_burst_cnt + 3'd1;
            end
        end
    end

    assign rf_write_addr = wb_rd;
    assign rf_write_data = wb_data;
    assign rf_read_addr1 = id_rs1;
    assign rf_read_addr2 = id_rs2;
    assign opnd1         = r_opnd1;
    assign opnd2         = r_opnd2;
    assign opnd_valid    = r_opnd_valid;
    assign grant_state   = r_grant;

endmodule

// File: tb/tb_id_rf_sched.sv
// Self-checking bench for id_rf_sched: directed stimulus, operand results checked
// through a scoreboard queue, control outputs checked against bench constants.
module tb_id_rf_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs2;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        control_j;
    logic        rf_op_write;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic [4:0]  rf_read_addr1;
    logic [4:0]  rf_read_addr2;
    logic [31:0] rf_read_value1;
    logic [31:0] rf_read_value2;
    logic [31:0] opnd1;
    logic [31:0] opnd2;
    logic        opnd_valid;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic [2:0]  grant_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] sb_q[$];
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    id_rf_sched #(.MAX_WB_BURST(2)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs2    (id_uses_rs2),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .wb_ready       (wb_ready),
        .control_j      (control_j),
        .rf_op_write    (rf_op_write),
        .rf_write_addr  (rf_write_addr),
        .rf_write_data  (rf_write_data),
        .rf_read_addr1  (rf_read_addr1),
        .rf_read_addr2  (rf_read_addr2),
        .rf_read_value1 (rf_read_value1),
        .rf_read_value2 (rf_read_value2),
        .opnd1          (opnd1),
        .opnd2          (opnd2),
        .opnd_valid     (opnd_valid),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .grant_state    (grant_state)
    );

    // Bench-side register file: reg i holds 0x100+i, except r3=0x11 and r5=0x22.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + 32'(i);
            rf[3] <= 32'h11;
            rf[5] <= 32'h22;
        end else if (rf_op_write && (rf_write_addr != 5'd0)) begin
            rf[rf_write_addr] <= rf_write_data;
        end
    end

    assign rf_read_value1 = rf[rf_read_addr1];
    assign rf_read_value2 = rf[rf_read_addr2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!reset && opnd_valid) begin
            if (sb_q.size() == 0) begin
                check("opnd_spurious", 32'(opnd_valid), 32'd0);
            end else begin
                logic [63:0] e;
                e = sb_q.pop_front();
                check("opnd1", opnd1, e[63:32]);
                check("opnd2", opnd2, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int prev_g;
        logic wr_exp;
        reset = 1'b1;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0;
        ex_mem_read = 0; ex_rd = 0; control_j = 0;
        wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h9;

        // Reset forces the combinational controls low even with a WB request.
        at_neg();
        check("rst_pc_write", 32'(pc_write), 32'd0);
        check("rst_ifid_write", 32'(ifid_write), 32'd0);
        check("rst_wb_ready", 32'(wb_ready), 32'd0);
        check("rst_rf_op_write", 32'(rf_op_write), 32'd0);
        check("rst_opnd_valid", 32'(opnd_valid), 32'd0);
        check("rst_grant", 32'(grant_state), 32'd0);
        tick();
        reset = 1'b0; wb_valid = 1'b0;

        // Plain read
        id_valid = 1; id_rs1 = 5'd3; id_rs2 = 5'd5; id_uses_rs2 = 1;
        at_neg();
        check("rd_op_write", 32'(rf_op_write), 32'd0);
        check("rd_pc_write", 32'(pc_write), 32'd1);
        check("rd_addr1", 32'(rf_read_addr1), 32'd3);
        sb_q.push_back({32'h11, 32'h22});
        tick();
        id_valid = 0;
        at_neg();
        check("rd_valid_n1", 32'(opnd_valid), 32'd1);
        check("rd_grant", 32'(grant_state), 32'd1);
        tick();
        at_neg();
        check("rd_valid_n2", 32'(opnd_valid), 32'd0);
        tick();

        // Arbitration with both requesters held: WR, WR, RD repeating
        id_valid = 1; id_rs1 = 5'd3; id_rs2 = 5'd5;
        wb_valid = 1; wb_rd = 5'd10; wb_data = 32'h1000;
        prev_g = 0;
        for (int i = 0; i < 6; i++) begin
            wr_exp = (i % 3) != 2;
            at_neg();
            check($sformatf("arb_wb_ready_%0d", i), 32'(wb_ready), 32'(wr_exp));
            check($sformatf("arb_grant_%0d", i), 32'(grant_state), 32'(prev_g));
            if (!wr_exp) sb_q.push_back({32'h11, 32'h22});
            prev_g = wr_exp ? 2 : 1;
            tick();
        end

        // Bypass once the burst limit forces a read
        wb_rd = 5'd20;
        for (int i = 0; i < 2; i++) begin
            at_neg();
            check($sformatf("byp_wr_%0d", i), 32'(wb_ready), 32'd1);
            tick();
        end
        wb_rd = 5'd3; wb_data = 32'hAB;
        at_neg();
        check("byp_rd_wb_ready", 32'(wb_ready), 32'd0);
        sb_q.push_back({32'hAB, 32'h22});
        tick();
        id_valid = 0;
        at_neg();
        check("byp_drain_wb_ready", 32'(wb_ready), 32'd1);
        check("byp_drain_pc_write", 32'(pc_write), 32'd1);
        tick();
        wb_valid = 0; id_valid = 1; id_rs1 = 5'd0; id_rs2 = 5'd3;
        at_neg();
        check("r0_op_write", 32'(rf_op_write), 32'd0);
        sb_q.push_back({32'h0, 32'hAB});
        tick();

        // Load-use stall on rs2, then the same without rs2 use
        id_rs1 = 5'd1; id_rs2 = 5'd7; id_uses_rs2 = 1; ex_mem_read = 1; ex_rd = 5'd7;
        at_neg();
        check("lu_pc_write", 32'(pc_write), 32'd0);
        check("lu_ifid_write", 32'(ifid_write), 32'd0);
        check("lu_op_write", 32'(rf_op_write), 32'd0);
        tick();
        ex_mem_read = 0;
        at_neg();
        check("lu_grant", 32'(grant_state), 32'd3);
        check("lu_opnd_valid", 32'(opnd_valid), 32'd0);
        check("lu_after_pc_write", 32'(pc_write), 32'd1);
        sb_q.push_back({32'h101, 32'h107});
        tick();
        ex_mem_read = 1; id_uses_rs2 = 0;
        at_neg();
        check("nolu_pc_write", 32'(pc_write), 32'd1);
        check("nolu_grant", 32'(grant_state), 32'd1);
        sb_q.push_back({32'h101, 32'h107});
        tick();

        // Jump together with a load-use hazard and a WB request
        id_uses_rs2 = 1; control_j = 1; wb_valid = 1; wb_rd = 5'd12; wb_data = 32'h5555;
        at_neg();
        check("j_flush", 32'(ifid_flush), 32'd1);
        check("j_pc_write", 32'(pc_write), 32'd1);
        check("j_ifid_write", 32'(ifid_write), 32'd0);
        check("j_wb_ready", 32'(wb_ready), 32'd1);
        tick();
        control_j = 0; ex_mem_read = 0; id_valid = 0; wb_valid = 0;
        at_neg();
        check("j_grant", 32'(grant_state), 32'd4);
        check("j_opnd_valid", 32'(opnd_valid), 32'd0);
        check("j_flush_off", 32'(ifid_flush), 32'd0);
        tick();

        // Reset during a burst clears the burst count
        id_valid = 1; id_rs1 = 5'd1; id_rs2 = 5'd7;
        at_neg();
        sb_q.push_back({32'h101, 32'h107});
        tick();
        wb_valid = 1; wb_rd = 5'd13; wb_data = 32'h77;
        at_neg();
        check("mb_wr", 32'(wb_ready), 32'd1);
        tick();
        reset = 1;
        at_neg();
        check("mb_rst_pc_write", 32'(pc_write), 32'd0);
        check("mb_rst_wb_ready", 32'(wb_ready), 32'd0);
        check("mb_rst_opnd_valid", 32'(opnd_valid), 32'd0);
        check("mb_rst_grant", 32'(grant_state), 32'd0);
        tick();
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            wr_exp = (i != 2);
            at_neg();
            check($sformatf("mb_wb_ready_%0d", i), 32'(wb_ready), 32'(wr_exp));
            if (!wr_exp) sb_q.push_back({32'h101, 32'h107});
            tick();
        end
        id_valid = 0; wb_valid = 0;
        at_neg();
        tick();
        at_neg();
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
